// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   DEFAULT_CLKS_PER_BIT : 50 MHz / 115200 baud
//   UART_IDLE_LEVEL      : line level when no frame is in flight
//   uart_rx_state_t      : receiver FSM states (RX_PARITY is used only when
//                          UART_RX_PARITY_EN is defined)
package uart_pkg;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
   localparam logic        UART_IDLE_LEVEL      = 1'b1;
   localparam int unsigned UART_BYTE_W          = 8;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_IDLE
   } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles behind d
module uart_sync2
   import uart_pkg::*;
#(
   parameter logic RESET_VAL = UART_IDLE_LEVEL
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         q      <= RESET_VAL;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with a
// one-entry valid/ready holding register.
// Ports:
//   clk           : system clock
//   reset_n       : asynchronous active-low reset
//   uart_rxd      : asynchronous serial line, idle high
//   rx_data       : received byte, zero-extended above DATA_BITS
//   rx_valid      : holding register full
//   rx_ready      : consumer accepts (transfer on rx_valid & rx_ready)
//   rx_busy       : frame in progress (start detected, not yet back in IDLE)
//   rx_frame_err  : one-cycle pulse, stop bit sampled low
//   rx_overrun    : one-cycle pulse, byte dropped because holding was full
//   rx_parity_err : one-cycle pulse on parity mismatch (0 without UART_RX_PARITY_EN)
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   uart_rxd,
   output logic [UART_BYTE_W-1:0] rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic                   rx_busy,
   output logic                   rx_frame_err,
   output logic                   rx_overrun,
   output logic                   rx_parity_err
);

   localparam int unsigned CW = 16;
   localparam int unsigned IW = 3;
   localparam int unsigned BW = UART_BYTE_W;

   localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_IDX    = IW'(DATA_BITS - 1);

   logic           rxs;
   uart_rx_state_t state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [BW-1:0]  shift_q, shift_d;
   logic [BW-1:0]  data_q, data_d;
   logic           valid_q, valid_d;
   logic           busy_q;
   logic           ferr_q, ferr_d;
   logic           ovr_q, ovr_d;
   logic           byte_done;
`ifdef UART_RX_PARITY_EN
   logic           par_q, par_d;
   logic           perr_q, perr_d;
`endif

   uart_sync2 #(.RESET_VAL(UART_IDLE_LEVEL)) u_sync (
      .clk   (clk),
      .rst_n (reset_n),
      .d     (uart_rxd),
      .q     (rxs)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= (state_d != RX_IDLE);
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   // Next-state, bit sampling and holding-register control
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q & ~rx_ready;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
      byte_done = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d     = par_q;
      perr_d    = 1'b0;
`endif

      case (state_q)
         RX_IDLE: begin
            if (!rxs) begin
               state_d = RX_START;
               cnt_d   = HALF_RELOAD;
            end
         end
         RX_START: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (rxs) begin
               state_d = RX_IDLE;   // glitch shorter than half a bit
            end else begin
               state_d = RX_DATA;
               idx_d   = '0;
               cnt_d   = BIT_RELOAD;
               shift_d = '0;
            end
         end
         RX_DATA: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shift_d[idx_q] = rxs;
               cnt_d          = BIT_RELOAD;
               if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                  state_d = RX_PARITY;
`else
                  state_d = RX_STOP;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         RX_PARITY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               par_d   = rxs;
               cnt_d   = BIT_RELOAD;
               state_d = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
`ifdef UART_RX_PARITY_EN
               perr_d = (^shift_q) ^ par_q;   // even parity over data + parity bit
`endif
               if (!rxs) begin
                  ferr_d  = 1'b1;
                  state_d = RX_WAIT_IDLE;
               end else begin
                  state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
                  byte_done = ~perr_d;
`else
                  byte_done = 1'b1;
`endif
               end
            end
         end
         RX_WAIT_IDLE: begin
            if (rxs) state_d = RX_IDLE;   // ride out a break before re-arming
         end
         default: state_d = RX_IDLE;
      endcase

      // Load when empty or being drained this cycle; otherwise drop the byte
      if (byte_done) begin
         if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_busy      = busy_q;
   assign rx_frame_err = ferr_q;
   assign rx_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign rx_parity_err = perr_q;
`else
   assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CLKS_PER_BIT=16.
// Stimulus pushes expected events (byte transfers and error pulses) into a
// queue; a negedge monitor pops and compares every event the DUT presents.
// Parity scenario runs only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

   localparam int unsigned CPB = 16;

   typedef enum logic [1:0] {EV_DATA, EV_FERR, EV_OVR, EV_PERR} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic [7:0]  data;
   } ev_t;

   logic       clk;
   logic       reset_n;
   logic       uart_rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_busy;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_parity_err;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .uart_rxd      (uart_rxd),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_busy       (rx_busy),
      .rx_frame_err  (rx_frame_err),
      .rx_overrun    (rx_overrun),
      .rx_parity_err (rx_parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic observe(input ev_kind_t k, input logic [7:0] d, input string name);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: unexpected event kind=%0d data=%02h, none required", name, k, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || (k == EV_DATA && e.data != d)) begin
            errors++;
            $display("FAIL %s: got kind=%0d data=%02h, required kind=%0d data=%02h",
                     name, k, d, e.kind, e.data);
         end
      end
   endtask

   // Monitor: every DUT-presented event must match the head of the queue
   always @(negedge clk) begin
      if (reset_n) begin
         if (rx_valid && rx_ready) observe(EV_DATA, rx_data, "transfer");
         if (rx_frame_err)         observe(EV_FERR, 8'h00, "frame_err");
         if (rx_overrun)           observe(EV_OVR, 8'h00, "overrun");
         if (rx_parity_err)        observe(EV_PERR, 8'h00, "parity_err");
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_bit(input logic b);
      uart_rxd = b;
      tick(CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                             input logic par_flip, input logic chk_busy);
      send_bit(1'b0);
      if (chk_busy) check("busy_after_start", 32'(rx_busy), 32'd1);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ par_flip);
`endif
      send_bit(stop_bit);
   endtask

   initial begin
      reset_n  = 1'b0;
      uart_rxd = 1'b1;
      rx_ready = 1'b0;
      tick(3);
      check("rst_valid", 32'(rx_valid), 32'd0);
      check("rst_data", 32'(rx_data), 32'd0);
      check("rst_busy", 32'(rx_busy), 32'd0);
      check("rst_errs", 32'({rx_frame_err, rx_overrun, rx_parity_err}), 32'd0);
      reset_n = 1'b1;
      tick(5);

      // 1: plain frame, consumer always ready
      rx_ready = 1'b1;
      expect_ev(EV_DATA, 8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      tick(4);
      check("t1_busy_done", 32'(rx_busy), 32'd0);
      check("t1_valid_dropped", 32'(rx_valid), 32'd0);

      // 2: short low glitch is a false start
      uart_rxd = 1'b0;
      tick(5);
      uart_rxd = 1'b1;
      tick(25);
      check("t2_busy", 32'(rx_busy), 32'd0);
      check("t2_valid", 32'(rx_valid), 32'd0);

      // 3: bad stop bit, line held low, then a good frame
      expect_ev(EV_FERR, 8'h00);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      tick(24);
      check("t3_wait_idle_busy", 32'(rx_busy), 32'd1);
      uart_rxd = 1'b1;
      tick(20);
      check("t3_idle_again", 32'(rx_busy), 32'd0);
      expect_ev(EV_DATA, 8'h11);
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      tick(20);

      // 4: overrun while consumer stalls, then drain
      rx_ready = 1'b0;
      expect_ev(EV_OVR, 8'h00);
      expect_ev(EV_DATA, 8'h01);
      send_frame(8'h01, 1'b1, 1'b0, 1'b0);
      send_frame(8'h02, 1'b1, 1'b0, 1'b0);
      tick(10);
      check("t4_valid_held", 32'(rx_valid), 32'd1);
      check("t4_data_held", 32'(rx_data), 32'h01);
      rx_ready = 1'b1;
      tick(1);
      check("t4_valid_drop", 32'(rx_valid), 32'd0);
      tick(10);

      // 5: reset during data bit 4 of 0xFF
      uart_rxd = 1'b0;
      tick(CPB);
      uart_rxd = 1'b1;
      tick(CPB * 4 + CPB / 2);
      reset_n = 1'b0;
      tick(2);
      check("t5_rst_busy", 32'(rx_busy), 32'd0);
      check("t5_rst_data", 32'(rx_data), 32'd0);
      check("t5_rst_valid", 32'(rx_valid), 32'd0);
      reset_n = 1'b1;
      tick(40);
      check("t5_idle_after_rst", 32'(rx_busy), 32'd0);
      expect_ev(EV_DATA, 8'h5A);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      tick(20);

`ifdef UART_RX_PARITY_EN
      // 6: good parity then bad parity
      expect_ev(EV_DATA, 8'h07);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      tick(10);
      expect_ev(EV_PERR, 8'h00);
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      tick(20);
      check("t6_no_valid", 32'(rx_valid), 32'd0);
`endif

      tick(20);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the counterpart of the transmitter that drives uart_txd in the sum-latch system.
- Deserialises 8N1 frames (LSB first) from an asynchronous line.
- Presents each byte on a one-entry valid/ready holding register for the downstream consumer (loopback checker or command decoder).
- Flags framing and overrun errors.
- Single clock domain; only uart_rxd is asynchronous.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal range 4..65535.
DATA_BITS, 8, data bits per frame; legal range 5..8; rx_data is zero-extended above DATA_BITS.

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
uart_rxd  input  1  serial line; idle high; asynchronous
rx_data  output  8  received byte; valid while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts; transfer on rx_valid & rx_ready
rx_busy  output  1  high from start-edge detection until return to IDLE
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_overrun  output  1  one-cycle pulse: byte completed while holding register still full and not being read
rx_parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without UART_RX_PARITY_EN

Behaviour:
Reset values:
- All outputs 0; rx_data 8'h00.
- Synchronizer flops reset to 1 (idle line).
- FSM in IDLE.

Input path: 2-flop synchronizer; the FSM sees rxs, delayed 2 cycles.

FSM states: IDLE, START, DATA, (PARITY), STOP, WAIT_IDLE.
- IDLE: rxs==0 -> START; bit counter := CLKS_PER_BIT/2 - 1 (integer division); rx_busy=1.
- START: counts down to 0, then samples rxs.
  - rxs==1: false start; -> IDLE, nothing reported.
  - rxs==0: -> DATA; bit index := 0; counter := CLKS_PER_BIT-1.
- DATA: each time the counter reaches 0, sample rxs into shift[index] (LSB first) and reload the counter.
  - After DATA_BITS samples -> STOP (PARITY first if enabled).
- STOP: sample at mid-bit.
  - rxs==1: byte complete -> IDLE the same edge.
  - rxs==0: rx_frame_err pulse; byte discarded; -> WAIT_IDLE.
- WAIT_IDLE: remain until rxs==1 (break tolerance), then -> IDLE. No start is detected while in WAIT_IDLE.

Output holding register (byte complete):
- Holding empty, or being read (rx_valid & rx_ready) on the same cycle: load rx_data; rx_valid=1 the next cycle.
- Otherwise: the new byte is dropped, the old byte is kept, rx_overrun pulses.

Handshake:
- rx_valid deasserts the cycle after rx_valid & rx_ready, unless a new load occurs on the same edge.
- rx_data is stable while rx_valid=1.
- The consumer may hold rx_ready high permanently.

Latency: rx_valid rises 1 cycle after the mid-stop-bit sample, i.e. 3 cycles after the line mid-stop point including the synchronizer.

Back-to-back frames: a start edge arriving immediately after the stop sample is detected from IDLE with no lost cycle.

Mid-operation reset: reset_n low at any point aborts the frame immediately and forces reset values; no pulse is emitted.

Optional Feature:
UART_RX_PARITY_EN
- Defined: frame is 8E1. PARITY state follows DATA and samples the bit at mid-bit.
  - Expected parity = XOR of data bits XOR sampled bit = 0.
  - Mismatch: rx_parity_err pulses at the stop sample and the byte is discarded, even if the stop bit is good.
  - Frame and parity errors may pulse on the same cycle.
- Undefined: no PARITY state; rx_parity_err tied 0.

Decomposition:
- Package uart_pkg: state enum type uart_rx_state_t; DEFAULT_CLKS_PER_BIT = 434; UART_IDLE_LEVEL = 1'b1. Shared with the transmitter.
- Sub-module: uart_sync2 (2-flop synchronizer, reset value parameterised, default 1). Reusable for the save_a_n/save_b_n buttons.

Test Plan:
All scenarios run with CLKS_PER_BIT=16.
1. Drive frame 0xA5, rx_ready=1 -> rx_valid pulses one cycle with rx_data=8'hA5; rx_busy high for ~160 cycles; no error pulses.
2. Low glitch of 5 cycles on uart_rxd -> returns to IDLE; rx_valid, rx_busy-after-glitch, and all error outputs stay 0.
3. Frame 0x3C with stop bit 0, line held low 40 cycles -> rx_frame_err single pulse; no rx_valid; next valid frame 0x11 is received correctly.
4. rx_ready=0, frames 0x01 then 0x02 back-to-back -> rx_valid=1 with rx_data=8'h01 held; rx_overrun pulses at the end of the second frame. Then rx_ready=1 -> 0x01 transferred, rx_valid drops.
5. reset_n pulsed low during data bit 4 of 0xFF -> outputs at reset values; following frame 0x5A received as 8'h5A.
6. (UART_RX_PARITY_EN) 0x07 with parity 1 -> valid 8'h07; 0x07 with parity 0 -> rx_parity_err pulse, no rx_valid.
